alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer sharing one 8-bit ALU datapath among `NUM_REQ` requesters. It accepts one operation at a time over a per-requester valid/ready handshake and executes it on an instantiated `alu_core`. It returns a registered 16-bit result, a zero flag and the requester ID over a single response channel with backpressure. It sits between the requesting units and the shared arithmetic resource.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)`, requester ID width
- `clk`  input  1  single clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `req_valid`  input  NUM_REQ  per-requester operation valid
- `req_ready`  output  NUM_REQ  per-requester accept; one-hot or zero
- `req_a`  input  NUM_REQ*8  operand A, requester i at bits [8i+7:8i]
- `req_b`  input  NUM_REQ*8  operand B, same packing
- `req_op`  input  NUM_REQ*3  opcode, same packing (3 bits per requester)
- `resp_valid`  output  1  response valid
- `resp_ready`  input  1  response consumer accept
- `resp_id`  output  ID_W  requester that issued the operation
- `resp_result`  output  16  operation result
- `resp_zero`  output  1  result == 0 (forced 0 when `resp_err`)
- `resp_err`  output  1  divide by zero
- `stat_grants`  output  NUM_REQ*16  grant counters (only with `ALU_ARB_STATS_EN`)

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid`, pick the winner round-robin starting at `rr_ptr`, assert `req_ready[winner]` combinationally in the same cycle, capture a/b/op/id, go to EXEC. Otherwise stay.
  - EXEC: `alu_core` evaluates the captured operands; result, zero and err are registered; go to RESP.
  - RESP: `resp_valid`=1. All response outputs stay stable until `resp_ready`. On handshake set `rr_ptr` = winner+1 mod NUM_REQ, go to IDLE.
- `req_ready` is asserted only in IDLE and only to the winner. A requester must hold its valid and payload until ready.
- Opcodes (enum `alu_op_e`): 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 PASS.
- Width rules:
  - ADD: 9-bit sum zero-extended to 16.
  - SUB: 16-bit two's complement of a−b (e.g. 3−5 = 16'hFFFE).
  - MUL: full 16-bit product.
  - DIV: unsigned quotient zero-extended. If b==0, result 16'hFFFF, `resp_err`=1, `resp_zero`=0.
  - AND/OR/XOR/PASS(a): zero-extended.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_result`=0, `resp_zero`=0, `resp_err`=0, `rr_ptr`=0, state IDLE, counters 0.
- Reset mid-operation: the in-flight operation is discarded with no response. A requester granted in that cycle is considered consumed.
- A requester dropping valid while not granted is legal and ignored.

## Timing
- Grant in cycle N (IDLE) → `resp_valid` high from N+2.
- Minimum 3 cycles per operation, with `resp_ready` tied high: grant, execute, response.
- `resp_ready` held low: RESP holds indefinitely and no new grant is issued.
- `resp_ready` high and a new `req_valid` present in the same cycle: the handshake completes that cycle; the next grant occurs in the following IDLE cycle using the updated `rr_ptr`.
- Simultaneous requests from all requesters: grants rotate as 0,1,2,3,0… from reset.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Per-requester 16-bit grant counters, incremented on each grant and saturating at 16'hFFFF.
  - Exposed on `stat_grants`, requester i at bits [16i+15:16i]; cleared by `rst`.
- `ALU_ARB_STATS_EN` undefined: the counters and the `stat_grants` port do not exist. All other behaviour is identical.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e` (3-bit enum above)
  - `arb_state_e` (IDLE, EXEC, RESP)
  - constants `ALU_DATA_W`=8, `ALU_RES_W`=16, `DIV0_RESULT`=16'hFFFF
- Sub-module `alu_core`: purely combinational, inputs a, b, op; outputs result[15:0], zero, err; implements the width rules. The arbiter registers its outputs in EXEC.
- The arbiter holds the FSM, round-robin pointer, operand capture registers, response registers and optional counters.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0; first grant after release goes to requester 0.
- Single op: requester 2 sends ADD a=200 b=100 → `req_ready[2]` in the valid cycle; 2 cycles later `resp_valid`, `resp_id`=2, `resp_result`=300, `resp_zero`=0.
- Width cases:
  - SUB 3−5 → 16'hFFFE.
  - MUL 255×255 → 65025.
  - DIV 7/0 → 16'hFFFF, `resp_err`=1, `resp_zero`=0.
  - XOR 0x5A^0x5A → 0, `resp_zero`=1.
- Fairness: all 4 requesters valid continuously for 8 ops → `resp_id` sequence 0,1,2,3,0,1,2,3; with `ALU_ARB_STATS_EN`, each counter = 2.
- Backpressure: hold `resp_ready` low 5 cycles in RESP → `resp_*` stable, `req_ready` stays 0; the release cycle completes the handshake and the next grant follows one cycle later.
- Mid-op reset: assert `rst` in EXEC → no `resp_valid` afterwards; state IDLE, `rr_ptr`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its combinational core.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned ALU_RES_W  = 16;

  localparam logic [ALU_RES_W-1:0] DIV0_RESULT = 16'hFFFF;

  // Opcode encoding carried on req_op, 3 bits per requester
  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpMul  = 3'd2,
    OpDiv  = 3'd3,
    OpAnd  = 3'd4,
    OpOr   = 3'd5,
    OpXor  = 3'd6,
    OpPass = 3'd7
  } alu_op_e;

  // Sequencer states: grant/capture, execute, hold response
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU producing a 16-bit result, zero and
// divide-by-zero flags. All results are zero-extended except SUB, which is the
// full 16-bit two's complement difference.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  input  alu_op_e               op,
  output logic [ALU_RES_W-1:0]  result,
  output logic                  zero,
  output logic                  err
);

  logic [ALU_RES_W-1:0] a_ext;
  logic [ALU_RES_W-1:0] b_ext;

  assign a_ext = {{(ALU_RES_W - ALU_DATA_W){1'b0}}, a};
  assign b_ext = {{(ALU_RES_W - ALU_DATA_W){1'b0}}, b};

  // Decode opcode into result and flags
  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (op)
      // Operands are zero-extended, so the 9-bit carry lands in bit 8
      OpAdd:  result = a_ext + b_ext;
      OpSub:  result = a_ext - b_ext;
      OpMul:  result = a_ext * b_ext;
      OpDiv: begin
        if (b == '0) begin
          result = DIV0_RESULT;
          err    = 1'b1;
        end else begin
          result = a_ext / b_ext;
        end
      end
      OpAnd:  result = a_ext & b_ext;
      OpOr:   result = a_ext | b_ext;
      OpXor:  result = a_ext ^ b_ext;
      OpPass: result = a_ext;
      default: result = '0;
    endcase
    // Divide-by-zero never reports zero even though the flag logic could
    zero = (result == '0) && !err;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu_core among NUM_REQ requesters.
// One operation in flight at a time: IDLE grants and captures, EXEC registers
// the ALU outputs, RESP holds the response until resp_ready.
// Optional feature: define ALU_ARB_STATS_EN to add saturating per-requester
// grant counters exposed on stat_grants.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ALU_DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*ALU_DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]            req_op,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [ID_W-1:0]                 resp_id,
  output logic [ALU_RES_W-1:0]            resp_result,
  output logic                            resp_zero,
  output logic                            resp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           stat_grants
`endif
);

  arb_state_e            state_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [ALU_DATA_W-1:0] a_q;
  logic [ALU_DATA_W-1:0] b_q;
  alu_op_e               op_q;

  logic                  resp_valid_q;
  logic [ALU_RES_W-1:0]  result_q;
  logic                  zero_q;
  logic                  err_q;

  logic                  any_valid;
  logic [ID_W-1:0]       win_id;
  int unsigned           idx;
  logic [ID_W-1:0]       next_ptr;

  logic [ALU_RES_W-1:0]  core_result;
  logic                  core_zero;
  logic                  core_err;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
`endif

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Ready goes to the winner only while idle; held off during reset
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle) && any_valid) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Pointer moves past the requester that just completed, wrapping at NUM_REQ
  assign next_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  alu_core u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_result),
    .zero   (core_zero),
    .err    (core_err)
  );

  // Sequencer FSM with operand capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OpAdd;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            id_q    <= win_id;
            a_q     <= req_a[ALU_DATA_W*win_id +: ALU_DATA_W];
            b_q     <= req_b[ALU_DATA_W*win_id +: ALU_DATA_W];
            op_q    <= alu_op_e'(req_op[3*win_id +: 3]);
            state_q <= StExec;
`ifdef ALU_ARB_STATS_EN
            if (grant_cnt_q[win_id] != 16'hFFFF) begin
              grant_cnt_q[win_id] <= grant_cnt_q[win_id] + 16'd1;
            end
`endif
          end
        end
        StExec: begin
          result_q     <= core_result;
          zero_q       <= core_zero;
          err_q        <= core_err;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= next_ptr;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[16*g +: 16] = grant_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued at grant
// time and popped when resp_valid is seen. Inputs change on the falling edge.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     res;
    logic            z;
    logic            e;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a = '0;
  logic [NUM_REQ*8-1:0] req_b = '0;
  logic [NUM_REQ*3-1:0] req_op = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [ID_W-1:0]      resp_id;
  logic [15:0]          resp_result;
  logic                 resp_zero;
  logic                 resp_err;
`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_grants;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_zero  (resp_zero),
    .resp_err   (resp_err)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op);
    exp_t m;
    m.id = ID_W'(id);
    m.e  = 1'b0;
    case (op)
      3'd0: m.res = {7'd0, {1'b0, a} + {1'b0, b}};
      3'd1: m.res = {8'd0, a} - {8'd0, b};
      3'd2: m.res = {8'd0, a} * {8'd0, b};
      3'd3: begin
        if (b == 8'd0) begin
          m.res = 16'hFFFF;
          m.e   = 1'b1;
        end else begin
          m.res = {8'd0, a / b};
        end
      end
      3'd4: m.res = {8'd0, a & b};
      3'd5: m.res = {8'd0, a | b};
      3'd6: m.res = {8'd0, a ^ b};
      default: m.res = {8'd0, a};
    endcase
    m.z = (m.res == 16'd0) && !m.e;
    return m;
  endfunction

  task automatic set_payload(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op);
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
    req_op[3*id +: 3] = op;
  endtask

  // Raise valid, wait for this requester's grant, queue the expectation, drop valid.
  // Returns on the falling edge of the EXEC cycle.
  task automatic drive_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input exp_t e);
    bit got = 1'b0;
    set_payload(id, a, b, op);
    req_valid[id] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (req_ready[id]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout id=%0d req_ready=%b", id, req_ready);
    end else begin
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (resp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout resp_valid=%b", resp_valid);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit   seen;
    exp_t e;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_payload(i, 8'(10 + i), 8'd1, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b id=%0d res=%h z=%b e=%b want all 0",
               req_ready, resp_valid, resp_id, resp_result, resp_zero, resp_err);
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if (stat_grants !== '0) begin
      errors++;
      $display("FAIL reset_stats got %h want 0", stat_grants);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b want 0001", req_ready);
    end
    sb.push_back(model(0, 8'd10, 8'd1, 3'd0));
    @(negedge clk);
    req_valid = '0;
    wait_resp(seen);
    if (seen) begin
      e = sb.pop_front();
      checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
        errors++;
        $display("FAIL reset_first_resp got id=%0d res=%h want id=%0d res=%h",
                 resp_id, resp_result, e.id, e.res);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e;
    set_payload(2, 8'd200, 8'd100, 3'd0);
    req_valid[2] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready got %b want 0100", req_ready);
    end
    sb.push_back('{id: 2'd2, res: 16'd300, z: 1'b0, e: 1'b0});
    @(negedge clk);
    req_valid[2] = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid got %b want 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency resp_valid got %b want 1", resp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
        errors++;
        $display("FAIL single_resp got id=%0d res=%0d z=%b e=%b want id=%0d res=%0d z=%b e=%b",
                 resp_id, resp_result, resp_zero, resp_err, e.id, e.res, e.z, e.e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_widths();
    // {a, b, op, expected result, zero, err}
    logic [7:0]  ta[10] = '{8'd3,   8'd255, 8'd7, 8'h5A, 8'd200, 8'hF0, 8'h0F, 8'hA5, 8'hFF,
                            8'd5};
    logic [7:0]  tb[10] = '{8'd5,   8'd255, 8'd0, 8'h5A, 8'd7,   8'h3C, 8'h30, 8'h00, 8'hFF,
                            8'd5};
    logic [2:0]  to[10] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd1};
    logic [15:0] tr[10] = '{16'hFFFE, 16'd65025, 16'hFFFF, 16'h0000, 16'd28, 16'h0030,
                            16'h003F, 16'h00A5, 16'h01FE, 16'h0000};
    logic        tz[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        te[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          seen;
    exp_t        e;
    for (int k = 0; k < 10; k++) begin
      drive_op(k % NUM_REQ, ta[k], tb[k], to[k],
               '{id: ID_W'(k % NUM_REQ), res: tr[k], z: tz[k], e: te[k]});
      wait_resp(seen);
      if (seen) begin
        e = sb.pop_front();
        checks++;
        if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
          errors++;
          $display("FAIL width_%0d got id=%0d res=%h z=%b e=%b want id=%0d res=%h z=%b e=%b",
                   k, resp_id, resp_result, resp_zero, resp_err, e.id, e.res, e.z, e.e);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    int   done = 0;
    exp_t e;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_payload(i, 8'(20 + 30 * i), 8'(3 + i), 3'(i));
    req_valid = '1;
    for (int n = 0; n < 100 && done < 8; n++) begin
      #1;
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL fair_onehot got %b want one-hot or zero", req_ready);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) sb.push_back(model(i, 8'(20 + 30 * i), 8'(3 + i), 3'(i)));
      end
      if (resp_valid) begin
        e = sb.pop_front();
        checks++;
        if (resp_id !== ID_W'(done % NUM_REQ) ||
            {resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
          errors++;
          $display("FAIL fair_%0d got id=%0d res=%h want id=%0d res=%h",
                   done, resp_id, resp_result, done % NUM_REQ, e.res);
        end
        done++;
      end
      if (done < 8) @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (done != 8) begin
      errors++;
      $display("FAIL fair_count got %0d responses want 8", done);
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (stat_grants[16*i +: 16] !== 16'd2) begin
        errors++;
        $display("FAIL fair_stat_%0d got %0d want 2", i, stat_grants[16*i +: 16]);
      end
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit   seen;
    exp_t e;
    bit   bad = 1'b0;
    resp_ready = 1'b0;
    drive_op(1, 8'd12, 8'd11, 3'd2, '{id: 2'd1, res: 16'd132, z: 1'b0, e: 1'b0});
    set_payload(0, 8'd1, 8'd2, 3'd0);
    set_payload(3, 8'd40, 8'd2, 3'd1);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    wait_resp(seen);
    e = sb.pop_front();
    for (int n = 0; n < 5; n++) begin
      #1;
      if (resp_valid !== 1'b1 || req_ready !== '0 ||
          {resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold got v=%b rdy=%b id=%0d res=%h want v=1 rdy=0 id=%0d res=%h",
               resp_valid, req_ready, resp_id, resp_result, e.id, e.res);
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_grant got v=%b rdy=%b want v=0 rdy=1000", resp_valid, req_ready);
    end
    if (req_ready[3]) sb.push_back('{id: 2'd3, res: 16'd38, z: 1'b0, e: 1'b0});
    @(negedge clk);
    req_valid = '0;
    wait_resp(seen);
    if (seen) begin
      e = sb.pop_front();
      checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
        errors++;
        $display("FAIL bp_after got id=%0d res=%h want id=%0d res=%h",
                 resp_id, resp_result, e.id, e.res);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_midop_reset();
    bit   seen;
    bit   bad = 1'b0;
    exp_t e;
    drive_op(1, 8'd1, 8'd1, 3'd0, '{id: 2'd1, res: 16'd2, z: 1'b0, e: 1'b0});
    wait_resp(seen);
    if (seen) void'(sb.pop_front());
    @(negedge clk);
    drive_op(2, 8'd9, 8'd9, 3'd0, '{id: 2'd2, res: 16'd18, z: 1'b0, e: 1'b0});
    // Now in EXEC: the queued expectation is discarded along with the operation
    if (sb.size() > 0) void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (resp_valid !== 1'b0 || resp_result !== 16'd0 || resp_id !== '0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet got v=%b id=%0d res=%h want v=0 id=0 res=0",
               resp_valid, resp_id, resp_result);
    end
    for (int i = 0; i < NUM_REQ; i++) set_payload(i, 8'(50 + i), 8'd0, 3'd7);
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr got %b want 0001", req_ready);
    end
    if (req_ready[0]) sb.push_back(model(0, 8'd50, 8'd0, 3'd7));
    @(negedge clk);
    req_valid = '0;
    wait_resp(seen);
    if (seen) begin
      e = sb.pop_front();
      checks++;
      if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.res, e.z, e.e}) begin
        errors++;
        $display("FAIL midrst_resp got id=%0d res=%h want id=%0d res=%h",
                 resp_id, resp_result, e.id, e.res);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_widths();
    test_fairness();
    test_backpressure();
    test_midop_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
